// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle FETCH/DECODE/EXEC/MEM/WB stage sequencer; optional counters via PERF_CNT_EN
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int WAIT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_write,
  output logic        pc_write,
  output logic        retired,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  // Instruction classes captured in DECODE; they steer EXEC/MEM/WB.
  localparam logic [2:0] C_ALU = 3'd0;
  localparam logic [2:0] C_BR  = 3'd1;
  localparam logic [2:0] C_JAL = 3'd2;
  localparam logic [2:0] C_LW  = 3'd3;
  localparam logic [2:0] C_SW  = 3'd4;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam bit TIMEOUT_ON = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = TIMEOUT_ON ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  logic [2:0]        state_next;
  logic [2:0]        cls;
  logic [2:0]        dec_cls;
  logic              dec_legal;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              expired;
  logic              retire;
  logic [1:0]        trap_code;

  // Classify the opcode/func pair; anything not listed is illegal.
  always_comb begin
    dec_cls   = C_ALU;
    dec_legal = 1'b1;
    case (opcode)
      6'h00: begin
        case (func)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: dec_cls = C_ALU;
          6'h08:   dec_cls = C_BR;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: dec_cls = C_ALU;
      6'h23:                 dec_cls = C_LW;
      6'h2b:                 dec_cls = C_SW;
      6'h02, 6'h04, 6'h05:   dec_cls = C_BR;
      6'h03:                 dec_cls = C_JAL;
      default:               dec_legal = 1'b0;
    endcase
  end

  // A memory handshake is stalled when its request is up without ready.
  always_comb begin
    waiting = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
    expired = TIMEOUT_ON && (wait_cnt == WAIT_LAST);
    retire  = ((state == S_EXEC) && ((cls == C_BR) || (cls == C_JAL))) ||
              ((state == S_MEM) && dmem_ready && (cls == C_SW)) ||
              (state == S_WB);
  end

  // Next-state selection; a retiring instruction samples run to pick FETCH or IDLE.
  always_comb begin
    state_next = state;
    trap_code  = CAUSE_TIMEOUT;
    case (state)
      S_IDLE:   state_next = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (imem_ready)   state_next = S_DECODE;
        else if (expired) state_next = S_TRAP;
      end
      S_DECODE: begin
        trap_code  = CAUSE_ILLEGAL;
        state_next = dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (retire)                               state_next = run ? S_FETCH : S_IDLE;
        else if ((cls == C_LW) || (cls == C_SW))  state_next = S_MEM;
        else                                      state_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)   state_next = (cls == C_SW) ? (run ? S_FETCH : S_IDLE) : S_WB;
        else if (expired) state_next = S_TRAP;
      end
      S_WB:     state_next = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
  end

  // Stage strobes are decoded from the state; ready only gates the completing cycle.
  always_comb begin
    imem_req  = (state == S_FETCH);
    ir_write  = (state == S_FETCH) && imem_ready;
    dmem_req  = (state == S_MEM);
    dmem_we   = (state == S_MEM) && (cls == C_SW);
    reg_write = (state == S_WB) || ((state == S_EXEC) && (cls == C_JAL));
    pc_write  = retire;
    retired   = retire;
  end

  // State, instruction class and the sticky trap record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cls        <= C_ALU;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      state <= state_next;
      if (state == S_DECODE) cls <= dec_cls;
      if ((state_next == S_TRAP) && (state != S_TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= trap_code;
      end
    end
  end

  // Consecutive not-ready cycles of the handshake in progress; zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (waiting && (state_next == state)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef PERF_CNT_EN
  logic stall;

  assign stall = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);

  // Free-running retire and stall counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= 32'd0;
      stall_cnt   <= 32'd0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + 32'd1;
      if (stall)  stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`else
  assign retired_cnt = 32'd0;
  assign stall_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - self-checking bench for multicycle_sequencer
`timescale 1ns/1ps
module tb_multicycle_sequencer;

  localparam int TMO = 4;

  localparam int K_ILL = 0, K_ALU = 1, K_BR = 2, K_JAL = 3, K_LW = 4, K_SW = 5;

  // Strobe bundle order: {imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, retired}
  localparam logic [6:0] B_IREQ = 7'b1000000;
  localparam logic [6:0] B_IRW  = 7'b0100000;
  localparam logic [6:0] B_DREQ = 7'b0010000;
  localparam logic [6:0] B_DWE  = 7'b0001000;
  localparam logic [6:0] B_RW   = 7'b0000100;
  localparam logic [6:0] B_PCW  = 7'b0000010;
  localparam logic [6:0] B_RET  = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] func = 6'd0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;
  logic imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, retired;
  logic [2:0] state;
  logic trap;
  logic [1:0] trap_cause;
  logic [31:0] retired_cnt, stall_cnt;

  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .func(func),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_write(reg_write), .pc_write(pc_write), .retired(retired), .state(state),
    .trap(trap), .trap_cause(trap_cause), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int unsigned exp_ret = 0;
  int unsigned exp_stall = 0;
  logic exp_trap = 1'b0;
  logic [1:0] exp_cause = 2'b00;
  bit in_fetch = 1'b0;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] rfn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] iop [8]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    if (op == 6'h00) begin
      if (fn == 6'h08) return K_BR;
      foreach (rfn[i]) if (rfn[i] == fn) return K_ALU;
      return K_ILL;
    end
    foreach (iop[i]) if (iop[i] == op) return K_ALU;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2b) return K_SW;
    if (op == 6'h02 || op == 6'h04 || op == 6'h05) return K_BR;
    if (op == 6'h03) return K_JAL;
    return K_ILL;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_cnt(input string tag);
`ifdef PERF_CNT_EN
    check({tag, "_cnt"}, {retired_cnt, stall_cnt}, {exp_ret, exp_stall});
`else
    check({tag, "_cnt"}, {retired_cnt, stall_cnt}, 64'd0);
`endif
  endtask

  // One clock cycle: drive inputs at the falling edge, sample just after.
  task automatic cyc(input logic [2:0] st, input logic [6:0] sb, input logic r,
                     input logic ir, input logic dr, input string tag);
    @(negedge clk);
    run = r; imem_ready = ir; dmem_ready = dr;
    #1;
    check(tag, {state, imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, retired, trap, trap_cause},
               {st, sb, exp_trap, exp_cause});
    if (sb[0]) exp_ret++;
    if ((sb[6] && !ir) || (sb[4] && !dr)) exp_stall++;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check(tag, {state, imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, retired, trap, trap_cause,
                retired_cnt, stall_cnt}, 64'd0);
    exp_ret = 0; exp_stall = 0; exp_trap = 1'b0; exp_cause = 2'b00; in_fetch = 1'b0;
    @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) cyc(3'd7, 7'd0, rb(), rb(), rb(), "trap_hold");
  endtask

  // Expected trace of one instruction from its class and memory wait counts.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                           input bit r_ret, input bit rst_mem, output bit trapped);
    int k;
    logic [6:0] we;
    trapped = 1'b0;
    if (!in_fetch) cyc(3'd0, 7'd0, 1'b1, rb(), rb(), "idle_start");
    in_fetch = 1'b0;
    opcode = op; func = fn;
    k = kind_of(op, fn);
    for (int i = 0; i < fw; i++) begin
      cyc(3'd1, B_IREQ, rb(), 1'b0, rb(), "fetch_wait");
      if (i == TMO - 1) begin
        exp_trap = 1'b1; exp_cause = 2'b10; trap_hold(6); trapped = 1'b1; return;
      end
    end
    cyc(3'd1, B_IREQ | B_IRW, rb(), 1'b1, rb(), "fetch_ready");
    cyc(3'd2, 7'd0, rb(), rb(), rb(), "decode");
    case (k)
      K_ILL: begin
        exp_trap = 1'b1; exp_cause = 2'b01; trap_hold(12); trapped = 1'b1; return;
      end
      K_BR:  cyc(3'd3, B_PCW | B_RET, r_ret, rb(), rb(), "exec_branch");
      K_JAL: cyc(3'd3, B_PCW | B_RW | B_RET, r_ret, rb(), rb(), "exec_jal");
      K_ALU: begin
        cyc(3'd3, 7'd0, rb(), rb(), rb(), "exec_alu");
        cyc(3'd5, B_RW | B_PCW | B_RET, r_ret, rb(), rb(), "wb_alu");
      end
      default: begin
        we = (k == K_SW) ? B_DWE : 7'd0;
        cyc(3'd3, 7'd0, rb(), rb(), rb(), "exec_mem");
        for (int i = 0; i < mw; i++) begin
          cyc(3'd4, B_DREQ | we, rb(), rb(), 1'b0, "mem_wait");
          if (rst_mem) begin do_reset("rst_in_mem"); return; end
          if (i == TMO - 1) begin
            exp_trap = 1'b1; exp_cause = 2'b10; trap_hold(6); trapped = 1'b1; return;
          end
        end
        if (k == K_SW) begin
          cyc(3'd4, B_DREQ | B_DWE | B_PCW | B_RET, r_ret, rb(), 1'b1, "mem_sw");
        end else begin
          cyc(3'd4, B_DREQ, rb(), rb(), 1'b1, "mem_lw");
          cyc(3'd5, B_RW | B_PCW | B_RET, r_ret, rb(), rb(), "wb_lw");
        end
      end
    endcase
    in_fetch = r_ret;
  endtask

  initial begin
    bit t;
    logic [5:0] op, fn;
    int fw, mw;
    logic [5:0] rlist [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    logic [5:0] ilist [14] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                               6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};

    #12;
    check("reset_state", {state, imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, retired, trap, trap_cause,
                          retired_cnt, stall_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(3'd0, 7'd0, 1'b0, 1'b1, 1'b1, "idle_hold");

    run_instr(6'h00, 6'h21, 0, 0, 1'b1, 1'b0, t);
    check_cnt("addu");
    run_instr(6'h23, 6'h15, 0, 3, 1'b1, 1'b0, t);
    check_cnt("lw_wait3");
    run_instr(6'h2b, 6'h00, 0, 0, 1'b1, 1'b0, t);
    check_cnt("sw_zero_wait");

    run_instr(6'h03, 6'h11, 0, 0, 1'b0, 1'b0, t);
    cyc(3'd0, 7'd0, 1'b0, rb(), rb(), "idle_after_jal");

    run_instr(6'h3f, 6'h00, 0, 0, 1'b1, 1'b0, t);
    check("illegal_trapped", t, 1'b1);
    do_reset("reset_after_illegal");

    run_instr(6'h00, 6'h20, 4, 0, 1'b1, 1'b0, t);
    check("fetch_timeout", t, 1'b1);
    do_reset("reset_after_fetch_timeout");
    run_instr(6'h00, 6'h20, 3, 0, 1'b1, 1'b0, t);
    check("fetch_ready_last", t, 1'b0);

    run_instr(6'h23, 6'h00, 0, 4, 1'b1, 1'b0, t);
    check("mem_timeout", t, 1'b1);
    do_reset("reset_after_mem_timeout");

    run_instr(6'h23, 6'h00, 1, 2, 1'b1, 1'b1, t);
    cyc(3'd0, 7'd0, 1'b0, rb(), rb(), "idle_after_rst");

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom); fn = 6'($urandom);
      end else if (rb()) begin
        op = 6'h00; fn = rlist[$urandom_range(0, 16)];
      end else begin
        op = ilist[$urandom_range(0, 13)]; fn = 6'($urandom);
      end
      fw = ($urandom_range(0, 11) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
      mw = ($urandom_range(0, 11) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
      run_instr(op, fn, fw, mw, ($urandom_range(0, 3) != 0), 1'b0, t);
      if (t) do_reset("reset_random_trap");
      else check_cnt("random");
      if (!in_fetch && rb()) cyc(3'd0, 7'd0, 1'b0, rb(), rb(), "idle_random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
